// File: rtl/addsub_pkg.sv
// Shared types and default sizes for the sequential adder/subtractor.
package addsub_pkg;

  // Default operand width and per-cycle segment width
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG_W = 16;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_addsub_seg_adder.sv
// Combinational SEG_W-bit adder with carry in/out; the top reuses a single
// instance for every segment of the operands.
module seg_adder #(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/seq_addsub.sv
// Sequential add/subtract: adds one SEG_W segment per cycle, LSB segment
// first, through one shared seg_adder. Result and flags are registered and
// only change on the cycle the last segment completes.
// Optional feature: define SEQ_ADDSUB_SAT_EN to saturate on signed overflow.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

  state_t            state_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;      // already inverted for subtraction
  logic [WIDTH-1:0]  acc_reg;    // working sum, segments filled in over RUN
  logic              carry_reg;
  logic [IDXW-1:0]   idx_reg;
  logic [WIDTH-1:0]  sum_reg;
  logic              cout_reg;
  logic              ovf_reg;
  logic              zero_reg;

  logic [SEG_W-1:0]  a_seg [NSEG];
  logic [SEG_W-1:0]  b_seg [NSEG];
  logic [SEG_W-1:0]  seg_a;
  logic [SEG_W-1:0]  seg_b;
  logic [SEG_W-1:0]  seg_sum;
  logic              seg_cout;
  logic [WIDTH-1:0]  raw_next;
  logic [WIDTH-1:0]  sum_next;
  logic              ovf_next;
  logic              zero_next;

  // Split the operand registers into segments and merge the current
  // segment result into the working sum
  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      assign a_seg[gi] = a_reg[gi*SEG_W +: SEG_W];
      assign b_seg[gi] = b_reg[gi*SEG_W +: SEG_W];
      assign raw_next[gi*SEG_W +: SEG_W] =
        (idx_reg == IDXW'(gi)) ? seg_sum : acc_reg[gi*SEG_W +: SEG_W];
    end
  endgenerate

  assign seg_a = a_seg[idx_reg];
  assign seg_b = b_seg[idx_reg];

  seg_adder #(
    .SEG_W (SEG_W)
  ) u_seg_adder (
    .a    (seg_a),
    .b    (seg_b),
    .cin  (carry_reg),
    .sum  (seg_sum),
    .cout (seg_cout)
  );

  // Signed overflow: operands of equal sign produce a result of other sign
  assign ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (raw_next[WIDTH-1] != a_reg[WIDTH-1]);

`ifdef SEQ_ADDSUB_SAT_EN
  // Clamp to the most positive / most negative value on overflow
  assign sum_next = !ovf_next ? raw_next :
                    (a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign sum_next = raw_next;
`endif

  assign zero_next = (sum_next == '0);

  // Control FSM, operand capture, segment sequencing and result registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{sub}};
            carry_reg <= sub;
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= raw_next;
          carry_reg <= seg_cout;
          if (idx_reg == LAST_IDX) begin
            sum_reg   <= sum_next;
            cout_reg  <= seg_cout;
            ovf_reg   <= ovf_next;
            zero_reg  <= zero_next;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;

endmodule
